// File: rtl/mem_request_arbiter.sv
// mem_request_arbiter: round-robin sharing of one memory port between fetch, scalar and vector requesters
module mem_request_arbiter #(
   parameter int VLEN = 4,
   parameter int ADDR_W = 32
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   iREN,
   input  logic [ADDR_W-1:0]      iaddr,
   output logic                   iwait,
   output logic [31:0]            iload,
   input  logic                   dREN,
   input  logic                   dWEN,
   input  logic [ADDR_W-1:0]      daddr,
   input  logic [31:0]            dstore,
   output logic                   dwait,
   output logic [31:0]            dload,
   input  logic                   vREN,
   input  logic                   vWEN,
   input  logic [ADDR_W-1:0]      vaddr,
   input  logic [32*VLEN-1:0]     vstore,
   output logic                   vwait,
   output logic [32*VLEN-1:0]     vload,
   output logic                   ramREN,
   output logic                   ramWEN,
   output logic [ADDR_W-1:0]      ramaddr,
   output logic [31:0]            ramstore,
   input  logic [31:0]            ramload,
   input  logic                   ramready,
   output logic [1:0]             grant
);
   typedef enum logic [2:0] {IDLE, ISERV, DSERV, VSERV, VDONE} state_t;
   state_t state, next_state;
   logic [1:0] last, pick;
   logic [4:0] beat, next_beat;
   logic [ADDR_W-1:0] l_addr;
   logic [31:0] l_store, v_lane;
   logic l_wen, i_req, d_req, v_req, serv;
   logic [32*VLEN-1:0] l_vstore;

   assign i_req = iREN;
   assign d_req = dREN | dWEN;
   assign v_req = vREN | vWEN;

   // first active requester after the previous grantee, cyclic order I, D, V
   always_comb begin
      pick = (last == 2'd1) ? (d_req ? 2'd2 : v_req ? 2'd3 : i_req ? 2'd1 : 2'd0) :
             (last == 2'd2) ? (v_req ? 2'd3 : i_req ? 2'd1 : d_req ? 2'd2 : 2'd0) :
                              (i_req ? 2'd1 : d_req ? 2'd2 : v_req ? 2'd3 : 2'd0);
   end

   // next state and burst beat; a dropped vector request abandons the burst after the current beat
   always_comb begin
      next_state = state;
      next_beat = beat;
      case (state)
         IDLE: next_state = (pick == 2'd1) ? ISERV : (pick == 2'd2) ? DSERV : (pick == 2'd3) ? VSERV : IDLE;
         ISERV, DSERV: next_state = ramready ? IDLE : state;
         VSERV: if (ramready) begin
            next_beat = (!v_req || beat == 5'(VLEN-1)) ? 5'd0 : beat + 5'd1;
            next_state = !v_req ? IDLE : (beat == 5'(VLEN-1)) ? VDONE : VSERV;
         end
         VDONE: begin
            next_state = IDLE;
            next_beat = 5'd0;
         end
         default: next_state = IDLE;
      endcase
   end

   // state, round-robin pointer and the granted request's address/data
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         beat <= 5'd0;
         last <= 2'd3;
         l_addr <= '0;
         l_store <= '0;
         l_wen <= 1'b0;
         l_vstore <= '0;
      end else begin
         state <= next_state;
         beat <= next_beat;
         if (state == IDLE && pick != 2'd0) begin
            last <= pick;
            l_addr <= (pick == 2'd1) ? iaddr : (pick == 2'd2) ? daddr : vaddr;
            l_store <= (pick == 2'd2) ? dstore : 32'd0;
            l_wen <= (pick == 2'd2) ? dWEN : (pick == 2'd3) ? vWEN : 1'b0;
            if (pick == 2'd3) l_vstore <= vstore;
         end
      end
   end

   // vector read data is captured lane by lane as each beat completes
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) vload <= '0;
      else if (state == VSERV && ramready && !l_wen)
         for (int k = 0; k < VLEN; k++)
            if (beat == 5'(k)) vload[32*k +: 32] <= ramload;
   end

   // write data lane for the current beat
   always_comb begin
      v_lane = 32'd0;
      for (int k = 0; k < VLEN; k++)
         if (beat == 5'(k)) v_lane = l_vstore[32*k +: 32];
   end

   assign serv = (state == ISERV) || (state == DSERV) || (state == VSERV);
   assign ramREN = serv & !l_wen;
   assign ramWEN = serv & l_wen;
   assign ramaddr = (state == VSERV) ? l_addr + ADDR_W'({beat, 2'b00}) : l_addr;
   assign ramstore = (state == VSERV) ? v_lane : l_store;
   assign iwait = i_req & !(state == ISERV && ramready);
   assign dwait = d_req & !(state == DSERV && ramready);
   assign vwait = v_req & (state != VDONE);
   assign iload = ramload;
   assign dload = ramload;
   assign grant = (state == IDLE) ? 2'd0 : (state == ISERV) ? 2'd1 : (state == DSERV) ? 2'd2 : 2'd3;
endmodule

// File: tb/tb_mem_request_arbiter.sv
// tb_mem_request_arbiter: scoreboard bench for the three-way memory arbiter
module tb_mem_request_arbiter;
   localparam int VLEN = 4;
   typedef struct packed {logic wen; logic [31:0] addr; logic [31:0] data;} acc_t;

   logic CLK, RST, iREN, iwait, dREN, dWEN, dwait, vREN, vWEN, vwait;
   logic ramREN, ramWEN, ramready;
   logic [31:0] iaddr, daddr, vaddr, iload, dload, dstore, ramaddr, ramstore, ramload;
   logic [31:0] ld_base, ld_addr0;
   logic [32*VLEN-1:0] vstore, vload;
   logic [1:0] grant;
   acc_t exp_q[$];
   acc_t m;
   int n_chk = 0, n_fail = 0;

   mem_request_arbiter #(.VLEN(VLEN), .ADDR_W(32)) dut (
      .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
      .vREN(vREN), .vWEN(vWEN), .vaddr(vaddr), .vstore(vstore), .vwait(vwait), .vload(vload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramready(ramready), .grant(grant)
   );

   // memory model: read data is a per-test base plus the word offset from a per-test origin
   assign ramload = ld_base + ((ramaddr - ld_addr0) >> 2);

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic expect_acc(input logic w, input logic [31:0] a, input logic [31:0] d);
      acc_t e;
      e.wen = w;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic do_reset;
      RST = 1'b1;
      tick();
      RST = 1'b0;
   endtask

   // every completed memory access is matched against the next expected one
   always @(negedge CLK) begin
      if (!RST && (ramREN || ramWEN) && ramready) begin
         if (exp_q.size() == 0) check("ram_unexpected", ramaddr, 32'hFFFF_FFFF);
         else begin
            m = exp_q.pop_front();
            check("ram_addr", ramaddr, m.addr);
            check("ram_wen", ramWEN, m.wen);
            check("ram_ren", ramREN, !m.wen);
            if (m.wen) check("ram_store", ramstore, m.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0] gt [1:13];
      int n, st;
      RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; vREN = 0; vWEN = 0;
      iaddr = 0; daddr = 0; vaddr = 0; dstore = 0; vstore = '0; ramready = 1'b1;
      ld_base = 32'h1234_0000; ld_addr0 = 0;
      // reset state and single fetch
      iREN = 1'b1;
      tick(); tick();
      check("rst_grant", grant, 2'd0);
      check("rst_ren", ramREN, 1'b0);
      check("rst_wen", ramWEN, 1'b0);
      check("rst_vload", vload, '0);
      check("rst_iwait", iwait, 1'b1);
      check("rst_dwait", dwait, 1'b0);
      expect_acc(1'b0, 32'h0, 32'h0);
      RST = 1'b0;
      tick();
      check("f_grant", grant, 2'd1);
      check("f_ren", ramREN, 1'b1);
      check("f_addr", ramaddr, 32'h0);
      check("f_iwait", iwait, 1'b0);
      check("f_iload", iload, 32'h1234_0000);
      iREN = 1'b0;
      tick();
      check("f_idle", grant, 2'd0);
      check("f_idle_ren", ramREN, 1'b0);
      // round robin with all three requesters held
      iREN = 1; dREN = 1; vREN = 1; iaddr = 32'h0; daddr = 32'h100; vaddr = 32'h200;
      ld_base = 32'hA000_0000; ld_addr0 = 0;
      gt = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd1, 2'd0, 2'd2};
      expect_acc(0, 32'h0, 0); expect_acc(0, 32'h100, 0);
      for (int k = 0; k < 4; k++) expect_acc(0, 32'h200 + 32'(4*k), 0);
      expect_acc(0, 32'h0, 0); expect_acc(0, 32'h100, 0);
      do_reset();
      for (int c = 1; c <= 13; c++) begin
         tick();
         check($sformatf("rr_grant_c%0d", c), grant, gt[c]);
         if (c == 1) check("rr_dwait_pending", dwait, 1'b1);
         if (c == 8) check("rr_vwait_busy", vwait, 1'b1);
         if (c == 9) begin
            check("rr_vwait_done", vwait, 1'b0);
            check("rr_vload", vload, 128'hA0000083_A0000082_A0000081_A0000080);
         end
      end
      iREN = 0; dREN = 0; vREN = 0;
      tick();
      check("rr_idle", grant, 2'd0);
      // vector write burst wrapping past the top of the address space
      vWEN = 1; vaddr = 32'hFFFF_FFF8;
      vstore = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
      expect_acc(1, 32'hFFFF_FFF8, 32'hAAAA_0001); expect_acc(1, 32'hFFFF_FFFC, 32'hBBBB_0002);
      expect_acc(1, 32'h0000_0000, 32'hCCCC_0003); expect_acc(1, 32'h0000_0004, 32'hDDDD_0004);
      do_reset();
      n = 0;
      while (n < 20) begin
         tick();
         n++;
         if (!vwait) break;
      end
      check("vw_cycles", n, 5);
      check("vw_done_grant", grant, 2'd3);
      check("vw_done_wen", ramWEN, 1'b0);
      check("vw_done_ren", ramREN, 1'b0);
      tick();
      check("vw_wait_again", vwait, 1'b1);
      vWEN = 0;
      tick();
      check("vw_idle", grant, 2'd0);
      // vector read with three stall cycles per beat
      vREN = 1; vaddr = 32'h40; ld_base = 32'h10; ld_addr0 = 32'h40; ramready = 0;
      for (int k = 0; k < 4; k++) expect_acc(0, 32'h40 + 32'(4*k), 0);
      do_reset();
      n = 0; st = 0;
      while (n < 40) begin
         tick();
         n++;
         if (!vwait) break;
         if (ramREN || ramWEN) begin
            st++;
            ramready = (st == 4);
            if (st == 4) st = 0;
         end else ramready = 0;
      end
      check("vr_cycles", n, 17);
      check("vr_vload", vload, 128'h00000013_00000012_00000011_00000010);
      ramready = 1;
      tick();
      check("vr_wait_again", vwait, 1'b1);
      vREN = 0;
      tick(); tick();
      check("vr_vload_hold", vload, 128'h00000013_00000012_00000011_00000010);
      // scalar access with both read and write asserted is a write
      dREN = 1; dWEN = 1; daddr = 32'h300; dstore = 32'hDEAD_BEEF; ramready = 0;
      expect_acc(1, 32'h300, 32'hDEAD_BEEF);
      do_reset();
      tick();
      check("d_grant", grant, 2'd2);
      check("d_wen", ramWEN, 1'b1);
      check("d_ren", ramREN, 1'b0);
      check("d_addr", ramaddr, 32'h300);
      check("d_store", ramstore, 32'hDEAD_BEEF);
      check("d_wait_stall", dwait, 1'b1);
      ramready = 1;
      #1;
      check("d_wait_done", dwait, 1'b0);
      dREN = 0; dWEN = 0;
      tick();
      check("d_idle", grant, 2'd0);
      check("d_idle_wen", ramWEN, 1'b0);
      // reset in the middle of a vector burst
      vREN = 1; vaddr = 32'h80; ld_base = 32'h55; ld_addr0 = 32'h80;
      expect_acc(0, 32'h80, 0); expect_acc(0, 32'h84, 0);
      do_reset();
      tick(); tick(); tick();
      check("vr2_b2_addr", ramaddr, 32'h88);
      check("vr2_partial", vload, 128'h00000000_00000000_00000056_00000055);
      RST = 1; iREN = 1; iaddr = 32'h500;
      #1;
      check("mr_ren", ramREN, 1'b0);
      check("mr_wen", ramWEN, 1'b0);
      check("mr_grant", grant, 2'd0);
      check("mr_vload", vload, '0);
      check("mr_iwait", iwait, 1'b1);
      check("mr_vwait", vwait, 1'b1);
      expect_acc(0, 32'h500, 0);
      tick();
      RST = 0;
      tick();
      check("mr_i_first", grant, 2'd1);
      check("mr_i_addr", ramaddr, 32'h500);
      iREN = 0; vREN = 0;
      tick();
      check("mr_idle", grant, 2'd0);
      check("sb_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_request_arbiter.md
Name: mem_request_arbiter

Overview:
- Shares the single 32-bit memory port between three requesters: scalar instruction fetch (I), scalar data (D) and vector data (V).
- Arbitration is round-robin, with one memory access outstanding at a time.
- Vector requests are sequenced as VLEN-beat bursts at consecutive word addresses.
- Sits between the load/store unit and the RAM controller.

Parameters:
VLEN, 4, vector lanes = words per V burst (legal 1..16)
ADDR_W, 32, address width

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
iREN  in  1  instruction fetch request
iaddr  in  ADDR_W  fetch address
iwait  out  1  high while fetch not complete
iload  out  32  fetched word, valid when iREN & !iwait
dREN  in  1  scalar data read request
dWEN  in  1  scalar data write request
daddr  in  ADDR_W  scalar data address
dstore  in  32  scalar write data
dwait  out  1  high while scalar access not complete
dload  out  32  scalar read data, valid when dREN & !dwait
vREN  in  1  vector read request
vWEN  in  1  vector write request
vaddr  in  ADDR_W  vector base address (lane 0)
vstore  in  32*VLEN  vector write data, lane k at [32k+31:32k]
vwait  out  1  high while vector burst not complete
vload  out  32*VLEN  vector read data, lane k at [32k+31:32k]
ramREN  out  1  memory read strobe
ramWEN  out  1  memory write strobe
ramaddr  out  ADDR_W  memory address
ramstore  out  32  memory write data
ramload  in  32  memory read data
ramready  in  1  memory access completes this cycle
grant  out  2  current owner: 0 none, 1 I, 2 D, 3 V

Behaviour:
- States: IDLE, ISERV, DSERV, VSERV, VDONE. All transitions on CLK rising edge.
- Request handshake:
  - A requester asserts REN or WEN and holds address/data stable until its wait is low for one cycle; wait is that cycle's completion strobe.
  - REN and WEN both high: treated as a write.
  - wait = request & !completion, combinational. A requester with no request sees wait low.
- IDLE arbitration:
  - Among active requests, grant the first in order after pointer last, with cyclic order I→D→V→I.
  - Latch the granted address and data into internal registers, set last to the grantee, enter its SERV state.
  - No request: stay in IDLE with last unchanged.
  - Grant takes one cycle, so the earliest completion is the cycle after the request is first seen.
- I/D SERV state:
  - Drive ramREN/ramWEN from the latched type, plus the latched ramaddr/ramstore.
  - When ramready=1, the owner's wait goes low the same cycle. iload/dload = ramload (combinational pass-through, read only).
  - Next state IDLE. Strobes drop in IDLE.
- VSERV:
  - Beat counter b runs 0..VLEN-1.
  - ramaddr = latched vaddr + 4*b, wrapping modulo 2^ADDR_W. ramstore = lane b of latched vstore.
  - On ramready: for a read, capture ramload into vload lane b (registered); increment b.
  - On the ramready of beat VLEN-1, go to VDONE.
  - vwait stays high throughout VSERV.
- VDONE:
  - No memory strobes. vwait low for exactly one cycle; vload is complete and stable.
  - Next state IDLE, b=0.
  - vload holds its value until the next V read overwrites lanes.
- Outputs to non-owners: non-owning wait signals stay high while their request is pending. Owner data outputs are don't-care outside completion, except vload, which is registered.
- grant reflects the state: IDLE=0, ISERV=1, DSERV=2, VSERV/VDONE=3.
- Requester drops request mid-service:
  - The in-flight RAM access is still completed, with strobes held until ramready.
  - I/D then return to IDLE with the completion ignored.
  - For V, the remaining beats are abandoned after the current beat completes, going directly to IDLE.
- Reset (any time, including mid-burst):
  - state=IDLE, last=V (so I has first priority), b=0, vload=0, latched registers=0.
  - ramREN=ramWEN=0, grant=0, wait outputs follow their request inputs.
- ramready outside a SERV state is ignored.

Test Plan:
- Reset, iREN=1 iaddr=0x0, ramready held 1 → grant=1 at cycle 1, ramREN=1 ramaddr=0x0, iwait low at cycle 1, iload=ramload; back to IDLE at cycle 2.
- iREN, dREN=1 daddr=0x100, vREN=1 vaddr=0x200 all held from reset → grant sequence I, D, V, I, D…; no requester waits longer than two other services.
- VLEN=4, vWEN=1 vaddr=0xFFFFFFF8, vstore lanes {A,B,C,D}, ramready every cycle → ramaddr 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 with ramstore A,B,C,D; then VDONE with vwait low for one cycle.
- Vector read with ramready stalled 3 cycles per beat, ramload=0x10+b → vload={0x13,0x12,0x11,0x10}, vwait low once.
- dREN and dWEN both 1, dstore=0xDEADBEEF → ramWEN=1, ramREN=0.
- Assert RST during VSERV beat 2 → next cycle ramREN=ramWEN=0, grant=0, vload=0; after release, pending I is granted first.
